// File: rtl/eth_rx_parser.sv
// eth_rx_parser: receive-side Ethernet frame parser.
// Takes bytes from the MII receive stage (preamble included), hunts for the
// SFD, filters on destination MAC, captures source MAC and EtherType, and
// streams the payload with the trailing 4-byte FCS stripped.
// Optional feature: define ETH_RX_CRC_CHECK_EN to check the FCS (CRC-32)
// before issuing frame_ok; without it, every well-formed frame is accepted.
//
// Handshake: there is no backpressure. A byte is consumed on every rising
// clk edge where rx_valid_i is high; rx_last_i only counts on those edges.
// stb is a one-cycle strobe qualifying stream_o/sof_o/eof_o; frame_ok and
// frame_err are one-cycle verdict pulses, never high together.
module eth_rx_parser #(
    parameter int ACCEPT_BCAST = 1,
    parameter int MAX_FRAME    = 1518
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    input  logic        rx_last_i,
    input  logic [47:0] local_mac_i,
    output logic [7:0]  stream_o,
    output logic        stb,
    output logic        sof_o,
    output logic        eof_o,
    output logic [15:0] type_o,
    output logic [47:0] mac_o,
    output logic        frame_ok,
    output logic        frame_err,
    output logic        busy,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PRE     = 3'd1,
        DST     = 3'd2,
        SRC     = 3'd3,
        TYPE    = 3'd4,
        PAYLOAD = 3'd5,
        DROP    = 3'd6
    } state_t;

    state_t      state;
    logic [2:0]  idx;        // byte index within DST / SRC / TYPE fields
    logic [10:0] cnt;        // bytes since the first DST byte, saturating
    logic        match_loc;  // all DST bytes so far equal local_mac_i
    logic        match_bc;   // all DST bytes so far equal 0xFF
    logic [31:0] dly;        // 4-byte delay line, oldest byte in [31:24]
    logic [2:0]  fill;       // occupied delay-line slots, 0..4
    logic        sof_pend;   // next emitted byte is the first of the frame

    logic [10:0] cnt_next;
    logic        oversize;
    logic        byte_loc_hit;
    logic        byte_bc_hit;
    logic        dst_accept;
    logic        crc_ok;

    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] i);
        case (i)
            3'd0:    return mac[47:40];
            3'd1:    return mac[39:32];
            3'd2:    return mac[31:24];
            3'd3:    return mac[23:16];
            3'd4:    return mac[15:8];
            default: return mac[7:0];
        endcase
    endfunction

    assign dbg_state    = state;
    assign cnt_next     = (cnt == 11'h7FF) ? cnt : cnt + 11'd1;
    assign oversize     = {21'd0, cnt_next} > 32'(MAX_FRAME);
    assign byte_loc_hit = rx_data_i == mac_byte(local_mac_i, idx);
    assign byte_bc_hit  = rx_data_i == 8'hFF;
    assign dst_accept   = (match_loc && byte_loc_hit) ||
                          ((ACCEPT_BCAST != 0) && match_bc && byte_bc_hit);

`ifdef ETH_RX_CRC_CHECK_EN
    logic [31:0] crc;
    logic [31:0] crc_next;

    function automatic logic [31:0] crc32_step(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in ^ {24'd0, b};
        for (int k = 0; k < 8; k++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    assign crc_next = crc32_step(crc, rx_data_i);
    // Running over data plus FCS leaves the fixed CRC-32 residue.
    assign crc_ok   = crc_next == 32'hDEBB20E3;

    // CRC register: seeded at the SFD, accumulates every byte DST..FCS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= 32'd0;
        end else if (rx_valid_i) begin
            if ((state == IDLE || state == PRE) && rx_data_i == 8'hD5) begin
                crc <= 32'hFFFFFFFF;
            end else if (state == DST || state == SRC || state == TYPE || state == PAYLOAD) begin
                crc <= crc_next;
            end
        end
    end
`else
    assign crc_ok = 1'b1;
`endif

    // Main FSM with registered outputs; everything advances on valid bytes only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= 3'd0;
            cnt       <= 11'd0;
            match_loc <= 1'b0;
            match_bc  <= 1'b0;
            dly       <= 32'd0;
            fill      <= 3'd0;
            sof_pend  <= 1'b0;
            stream_o  <= 8'd0;
            stb       <= 1'b0;
            sof_o     <= 1'b0;
            eof_o     <= 1'b0;
            type_o    <= 16'd0;
            mac_o     <= 48'd0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            stb       <= 1'b0;
            sof_o     <= 1'b0;
            eof_o     <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            if (rx_valid_i) begin
                // Every non-last byte leaves the FSM outside IDLE, a last byte returns it there.
                busy <= ~rx_last_i;
                case (state)
                    IDLE, PRE: begin
                        if (rx_data_i == 8'h55) begin
                            state <= PRE;
                        end else if (rx_data_i == 8'hD5) begin
                            state     <= DST;
                            idx       <= 3'd0;
                            cnt       <= 11'd0;
                            match_loc <= 1'b1;
                            match_bc  <= 1'b1;
                        end else begin
                            state <= DROP;
                        end
                    end
                    DST: begin
                        cnt       <= cnt_next;
                        match_loc <= match_loc & byte_loc_hit;
                        match_bc  <= match_bc & byte_bc_hit;
                        frame_err <= rx_last_i | oversize;
                        if (idx == 3'd5) begin
                            idx   <= 3'd0;
                            state <= dst_accept ? SRC : DROP;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                        if (oversize) state <= DROP;
                    end
                    SRC: begin
                        cnt       <= cnt_next;
                        mac_o     <= {mac_o[39:0], rx_data_i};
                        frame_err <= rx_last_i | oversize;
                        if (idx == 3'd5) begin
                            idx   <= 3'd0;
                            state <= TYPE;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                        if (oversize) state <= DROP;
                    end
                    TYPE: begin
                        cnt       <= cnt_next;
                        type_o    <= {type_o[7:0], rx_data_i};
                        frame_err <= rx_last_i | oversize;
                        if (idx == 3'd1) begin
                            idx      <= 3'd0;
                            state    <= PAYLOAD;
                            fill     <= 3'd0;
                            sof_pend <= 1'b1;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                        if (oversize) state <= DROP;
                    end
                    PAYLOAD: begin
                        cnt <= cnt_next;
                        if (oversize) begin
                            // Oversize frames end here: error now, no eof_o ever.
                            frame_err <= 1'b1;
                            state     <= DROP;
                        end else begin
                            dly <= {dly[23:0], rx_data_i};
                            if (fill != 3'd4) fill <= fill + 3'd1;
                            if (fill == 3'd4) begin
                                stream_o <= dly[31:24];
                                stb      <= 1'b1;
                                sof_o    <= sof_pend;
                                eof_o    <= rx_last_i;
                                sof_pend <= 1'b0;
                            end
                            if (rx_last_i) begin
                                // Four or fewer payload bytes is FCS only: nothing delivered.
                                frame_ok  <= (fill == 3'd4) && crc_ok;
                                frame_err <= !((fill == 3'd4) && crc_ok);
                            end
                        end
                    end
                    DROP: begin
                        cnt <= cnt_next;
                    end
                    default: begin
                        state <= DROP;
                    end
                endcase
                if (rx_last_i) state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_eth_rx_parser.sv
// tb_eth_rx_parser: directed testbench for eth_rx_parser.
// Frames are built byte by byte (FCS generated here), driven on the falling
// edge, and outputs are sampled 1 ns after the rising edge. Payload bytes
// with their sof/eof flags go through an expected queue.
module tb_eth_rx_parser;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_last_i;
    logic [47:0] local_mac_i;
    logic [7:0]  stream_o;
    logic        stb;
    logic        sof_o;
    logic        eof_o;
    logic [15:0] type_o;
    logic [47:0] mac_o;
    logic        frame_ok;
    logic        frame_err;
    logic        busy;
    logic [2:0]  dbg_state;

`ifdef ETH_RX_CRC_CHECK_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

    int n_checks = 0;
    int n_errors = 0;
    int n_stb, n_sof, n_eof, n_ok, n_err;
    bit check_en;
    logic [9:0] exp_q[$];
    logic [7:0] fr[$];

    eth_rx_parser dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data_i   (rx_data_i),
        .rx_valid_i  (rx_valid_i),
        .rx_last_i   (rx_last_i),
        .local_mac_i (local_mac_i),
        .stream_o    (stream_o),
        .stb         (stb),
        .sof_o       (sof_o),
        .eof_o       (eof_o),
        .type_o      (type_o),
        .mac_o       (mac_o),
        .frame_ok    (frame_ok),
        .frame_err   (frame_err),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in ^ {24'd0, b};
        for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    task automatic make_frame(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] typ,
                              input int plen, input logic [7:0] p0, input bit add_fcs);
        logic [31:0] c;
        logic [7:0]  pb;
        fr.delete();
        for (int i = 5; i >= 0; i--) fr.push_back(dst[8*i +: 8]);
        for (int i = 5; i >= 0; i--) fr.push_back(src[8*i +: 8]);
        fr.push_back(typ[15:8]);
        fr.push_back(typ[7:0]);
        pb = p0;
        for (int i = 0; i < plen; i++) begin
            fr.push_back(pb);
            pb = pb + 8'd1;
        end
        if (add_fcs) begin
            c = 32'hFFFFFFFF;
            foreach (fr[i]) c = crc_step(c, fr[i]);
            c = ~c;
            fr.push_back(c[7:0]);
            fr.push_back(c[15:8]);
            fr.push_back(c[23:16]);
            fr.push_back(c[31:24]);
        end
    endtask

    task automatic expect_payload(input int plen);
        for (int i = 0; i < plen; i++) exp_q.push_back({i == 0, i == plen - 1, fr[14 + i]});
    endtask

    task automatic clear_counts();
        n_stb = 0; n_sof = 0; n_eof = 0; n_ok = 0; n_err = 0;
        exp_q.delete();
    endtask

    // Driver tasks
    task automatic drive_byte(input logic [7:0] b, input bit last);
        @(negedge clk);
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        rx_last_i  = last;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_valid_i = 1'b0;
            rx_last_i  = 1'b0;
            rx_data_i  = 8'd0;
        end
    endtask

    task automatic send_pre(input int n55, input bit gap);
        for (int i = 0; i < n55; i++) begin
            drive_byte(8'h55, 1'b0);
            if (gap) idle(1);
        end
        drive_byte(8'hD5, 1'b0);
        if (gap) idle(1);
    endtask

    task automatic send_body(input int from, input int to, input bit gap);
        for (int i = from; i < to; i++) begin
            drive_byte(fr[i], i == fr.size() - 1);
            if (gap && i < to - 1) idle(1);
        end
    endtask

    // Scoreboard / monitor: sampled 1 ns after each rising edge
    always @(posedge clk) begin
        logic [9:0] e;
        #1;
        if (stb) begin
            n_stb++;
            if (sof_o) n_sof++;
            if (eof_o) n_eof++;
            if (check_en) begin
                check("stb_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("stb_sof_eof_data", {sof_o, eof_o, stream_o}, e);
                end
            end
        end
        if (frame_ok) n_ok++;
        if (frame_err) n_err++;
        if (frame_ok || frame_err) check("ok_err_exclusive", frame_ok & frame_err, 0);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        rx_data_i   = 8'd0;
        rx_valid_i  = 1'b0;
        rx_last_i   = 1'b0;
        local_mac_i = 48'h0200_0000_0001;
        check_en    = 1'b0;
        clear_counts();
        idle(3);

        // Reset state
        check("rst_mac", mac_o, 0);
        check("rst_type", type_o, 0);
        check("rst_misc", {stream_o, stb, sof_o, eof_o, frame_ok, frame_err, busy}, 0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Broadcast frame, 46-byte payload, good FCS
        make_frame(BCAST, 48'h0011_2233_4455, 16'h0800, 46, 8'h01, 1'b1);
        clear_counts();
        check_en = 1'b1;
        expect_payload(46);
        send_pre(7, 1'b0);
        send_body(0, fr.size(), 1'b0);
        idle(4);
        check("bc_stb", n_stb, 46);
        check("bc_sof", n_sof, 1);
        check("bc_eof", n_eof, 1);
        check("bc_ok", n_ok, 1);
        check("bc_err", n_err, 0);
        check("bc_drained", exp_q.size(), 0);
        check("bc_mac", mac_o, 48'h0011_2233_4455);
        check("bc_type", type_o, 16'h0800);
        check("bc_busy", busy, 0);

        // Same frame, last FCS byte flipped
        fr[fr.size() - 1] = fr[fr.size() - 1] ^ 8'hFF;
        clear_counts();
        expect_payload(46);
        send_pre(7, 1'b0);
        send_body(0, fr.size(), 1'b0);
        idle(4);
        check("badfcs_stb", n_stb, 46);
        check("badfcs_eof", n_eof, 1);
        check("badfcs_ok", n_ok, CRC_EN ? 0 : 1);
        check("badfcs_err", n_err, CRC_EN ? 1 : 0);

        // Address-filtered frame
        make_frame(48'h0200_0000_0099, 48'hAABB_CCDD_EEFF, 16'h0800, 46, 8'h01, 1'b1);
        clear_counts();
        send_pre(7, 1'b0);
        send_body(0, fr.size(), 1'b0);
        check("filt_busy_at_last", busy, 1);
        idle(1);
        check("filt_busy_after", busy, 0);
        idle(3);
        check("filt_stb", n_stb, 0);
        check("filt_ok", n_ok, 0);
        check("filt_err", n_err, 0);
        check("filt_mac_hold", mac_o, 48'h0011_2233_4455);

        // Unicast to local MAC, SFD straight from IDLE, 3-byte payload
        make_frame(48'h0200_0000_0001, 48'h0A0B_0C0D_0E0F, 16'h88B5, 3, 8'hA0, 1'b1);
        clear_counts();
        expect_payload(3);
        send_pre(0, 1'b0);
        send_body(0, fr.size(), 1'b0);
        idle(4);
        check("uc_stb", n_stb, 3);
        check("uc_ok", n_ok, 1);
        check("uc_drained", exp_q.size(), 0);
        check("uc_mac", mac_o, 48'h0A0B_0C0D_0E0F);
        check("uc_type", type_o, 16'h88B5);

        // Runt: cut after 10 bytes post-SFD
        make_frame(BCAST, 48'h0011_2233_4455, 16'h0800, 46, 8'h01, 1'b1);
        while (fr.size() > 10) void'(fr.pop_back());
        clear_counts();
        send_pre(7, 1'b0);
        send_body(0, fr.size(), 1'b0);
        idle(4);
        check("runt_err", n_err, 1);
        check("runt_ok", n_ok, 0);
        check("runt_stb", n_stb, 0);

        // Payload region of exactly 4 bytes (FCS only)
        make_frame(BCAST, 48'h0011_2233_4455, 16'h0800, 0, 8'h00, 1'b1);
        clear_counts();
        send_pre(7, 1'b0);
        send_body(0, fr.size(), 1'b0);
        idle(4);
        check("short_err", n_err, 1);
        check("short_ok", n_ok, 0);
        check("short_stb", n_stb, 0);

        // Broadcast frame with rx_valid_i toggling every other cycle
        make_frame(BCAST, 48'h0011_2233_4455, 16'h0800, 46, 8'h01, 1'b1);
        clear_counts();
        expect_payload(46);
        send_pre(7, 1'b1);
        send_body(0, fr.size(), 1'b1);
        idle(4);
        check("gap_stb", n_stb, 46);
        check("gap_sof", n_sof, 1);
        check("gap_eof", n_eof, 1);
        check("gap_ok", n_ok, 1);
        check("gap_drained", exp_q.size(), 0);

        // Reset at payload byte 20, remnant dropped, then back-to-back clean frame
        check_en = 1'b0;
        clear_counts();
        send_pre(7, 1'b0);
        send_body(0, 34, 1'b0);
        @(negedge clk);
        rx_valid_i = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_stb_before", n_stb, 16);
        check("midrst_mac", mac_o, 0);
        check("midrst_type", type_o, 0);
        check("midrst_misc", {stream_o, stb, sof_o, eof_o, frame_ok, frame_err, busy}, 0);
        @(negedge clk);
        rst = 1'b0;
        clear_counts();
        send_body(34, fr.size(), 1'b0);
        make_frame(BCAST, 48'h6655_4433_2211, 16'h86DD, 46, 8'h01, 1'b1);
        check_en = 1'b1;
        expect_payload(46);
        send_pre(7, 1'b0);
        send_body(0, fr.size(), 1'b0);
        idle(4);
        check("after_rst_ok", n_ok, 1);
        check("after_rst_err", n_err, 0);
        check("after_rst_stb", n_stb, 46);
        check("after_rst_drained", exp_q.size(), 0);
        check("after_rst_mac", mac_o, 48'h6655_4433_2211);
        check("after_rst_type", type_o, 16'h86DD);

        // Oversize: byte 1519 counted from DST exceeds MAX_FRAME
        make_frame(BCAST, 48'h0011_2233_4455, 16'h0800, 1511, 8'h00, 1'b0);
        check_en = 1'b0;
        clear_counts();
        send_pre(7, 1'b0);
        send_body(0, fr.size(), 1'b0);
        idle(4);
        check("big_stb", n_stb, 1500);
        check("big_err", n_err, 1);
        check("big_ok", n_ok, 0);
        check("big_eof", n_eof, 0);
        check("big_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/eth_rx_parser.md
ETH_RX_PARSER -- requirements
Module: eth_rx_parser

Interface
REQ-001 Parameter ACCEPT_BCAST, default 1, accept destination ff:ff:ff:ff:ff:ff in addition to local_mac_i.
REQ-002 Parameter MAX_FRAME, default 1518, maximum byte count from destination MAC through FCS inclusive.
REQ-003 clk  input  1  single clock for all logic, rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 rx_data_i  input  8  received byte from the MII receive stage, preamble included.
REQ-006 rx_valid_i  input  1  rx_data_i valid this cycle; gaps of any length allowed.
REQ-007 rx_last_i  input  1  qualifies the final byte of a frame; meaningful only with rx_valid_i.
REQ-008 local_mac_i  input  48  station address, byte 0 in bits [47:40].
REQ-009 stream_o  output  8  payload byte.
REQ-010 stb  output  1  one-cycle strobe, stream_o valid.
REQ-011 sof_o / eof_o  output  1 each  set with stb on the first / last payload byte.
REQ-012 type_o  output  16  EtherType, first received byte in [15:8].
REQ-013 mac_o  output  48  source MAC, first received byte in [47:40].
REQ-014 frame_ok / frame_err  output  1 each  one-cycle end-of-frame verdict pulses.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states: IDLE, PRE, DST, SRC, TYPE, PAYLOAD, DROP; each state advances only on cycles with rx_valid_i high.
REQ-017 IDLE: 0x55 -> PRE; 0xD5 -> DST; any other byte -> DROP.
REQ-018 PRE: 0x55 stays in PRE, 0xD5 -> DST, any other byte -> DROP; the 0x55 count is not checked.
REQ-019 DST: compare 6 bytes against local_mac_i (or broadcast when ACCEPT_BCAST=1); any mismatch -> DROP after the 6th byte.
REQ-020 SRC: capture 6 bytes into mac_o; TYPE: capture 2 bytes into type_o; after the 2nd type byte -> PAYLOAD.
REQ-021 mac_o and type_o update only during capture and hold until the next frame's capture.
REQ-022 PAYLOAD: each byte enters a 4-byte delay line; once the line is full, the byte shifted out drives stream_o with stb high on the next cycle.
REQ-023 The last 4 bytes of a frame (FCS) never appear on stream_o.
REQ-024 eof_o marks the byte shifted out by the rx_last_i byte; latency rx_last_i -> eof_o/frame_ok/frame_err is 1 cycle.
REQ-025 If PAYLOAD ends with at most 4 bytes, no stb is issued; the verdict is frame_err.
REQ-026 Byte counter: 11 bits, starts at the first DST byte, saturates at 2047.
REQ-027 Counter exceeding MAX_FRAME -> frame_err pulse, then DROP; the frame emits no eof_o.
REQ-028 rx_last_i in DST, SRC or TYPE (runt) -> frame_err, then IDLE.
REQ-029 rx_last_i in any state returns the FSM to IDLE.
REQ-030 DROP discards bytes until rx_last_i, then IDLE; address-filtered frames pulse neither frame_ok nor frame_err.
REQ-031 frame_ok and frame_err are never high in the same cycle.
REQ-032 An rx_valid_i byte in the cycle after rx_last_i is treated as the first byte of a new frame in IDLE.

Reset
REQ-033 rst forces IDLE and clears the delay line, counter and CRC register.
REQ-034 rst sets stream_o, stb, sof_o, eof_o, type_o, mac_o, frame_ok, frame_err and busy to 0.
REQ-035 rst mid-frame discards that frame silently; the remainder of it is parsed from IDLE and, lacking a valid preamble/SFD, falls into DROP.

Configuration
REQ-036 Macro ETH_RX_CRC_CHECK_EN defined: CRC-32 computed over DST..FCS bytes (reflected poly 0xEDB88320, init 0xFFFFFFFF).
REQ-037 With the macro, on rx_last_i frame_ok pulses only if the register equals residue 0xDEBB20E3; otherwise frame_err.
REQ-038 Macro undefined: no CRC logic; the FCS is still stripped and frame_ok pulses on every frame that satisfies REQ-025 and REQ-027.

Verification
REQ-039 Broadcast frame: 7x55, D5, 6xFF, src 00:11:22:33:44:55, type 0800, payload 01..2E (46 bytes), valid FCS -> 46 stb; sof_o on 0x01, eof_o on 0x2E; mac_o=001122334455; type_o=0800; frame_ok=1.
REQ-040 Same frame with the FCS last byte flipped, macro defined -> 46 stb, then frame_err=1 and frame_ok=0.
REQ-041 Destination 02:00:00:00:00:99 with local_mac_i=020000000001 -> no stb, no verdict pulse, busy falls 1 cycle after rx_last_i.
REQ-042 Frame cut after 10 bytes post-SFD (rx_last_i on the 10th) -> frame_err=1, no stb.
REQ-043 rx_valid_i toggling every other cycle through REQ-039 -> identical output bytes and flags.
REQ-044 rst asserted at payload byte 20 -> all outputs 0; next clean frame received correctly with frame_ok=1.
